// File: rtl/game_pkg.sv
// Game-level types and defaults shared by the game control blocks.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARMED    = 3'd1,
    EVAL     = 3'd2,
    COOLDOWN = 3'd3,
    DONE     = 3'd4
  } shot_state_t;

  localparam int SHOTS_PER_DUCK_DEF = 3;
  localparam int DUCKS_PER_GAME_DEF = 10;
  localparam int COOLDOWN_MS        = 100;
  localparam int CLK_SYS_KHZ        = 65_000;

endpackage

// File: rtl/vga_pkg.sv
// Display geometry shared by the VGA pipeline and the game blocks.
package vga_pkg;

  localparam int DUCK_WIDTH  = 64;
  localparam int DUCK_HEIGHT = 64;

endpackage

// File: rtl/hit_box_check.sv
// Combinational point-in-box test; origin pixel is inside, origin+size is outside.
module hit_box_check #(
  parameter int BOX_W = 64,
  parameter int BOX_H = 64
) (
  input  logic [11:0] point_x_i,
  input  logic [11:0] point_y_i,
  input  logic [11:0] box_x_i,
  input  logic [11:0] box_y_i,
  output logic        hit_o
);

  // 13-bit edges so a box near the screen limit cannot wrap to zero
  logic [12:0] x_end;
  logic [12:0] y_end;

  assign x_end = {1'b0, box_x_i} + 13'(BOX_W);
  assign y_end = {1'b0, box_y_i} + 13'(BOX_H);

  assign hit_o = (point_x_i >= box_x_i) && ({1'b0, point_x_i} < x_end) &&
                 (point_y_i >= box_y_i) && ({1'b0, point_y_i} < y_end);

endmodule

// File: rtl/shot_ctl.sv
// Turns left-clicks into hit/escape events against the current duck box,
// keeps per-duck shots, score and ducks served, and signals game end.
//
// state    | meaning
// IDLE     | game inactive, counters held at reset values
// ARMED    | waiting for a click edge
// EVAL     | captured click tested against captured duck box
// COOLDOWN | dead time after a shot, clicks discarded
// DONE     | all ducks served, game_finished high
module shot_ctl
  import game_pkg::*;
#(
  parameter int DUCK_WIDTH      = vga_pkg::DUCK_WIDTH,
  parameter int DUCK_HEIGHT     = vga_pkg::DUCK_HEIGHT,
  parameter int SHOTS_PER_DUCK  = game_pkg::SHOTS_PER_DUCK_DEF,
  parameter int DUCKS_PER_GAME  = game_pkg::DUCKS_PER_GAME_DEF,
  parameter int COOLDOWN_CYCLES = game_pkg::COOLDOWN_MS * game_pkg::CLK_SYS_KHZ
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        game_enable,
  input  logic        left_mouse,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  input  logic [11:0] duck_xpos,
  input  logic [11:0] duck_ypos,
  output logic        duck_hit,
  output logic        duck_escaped,
  output logic [1:0]  shots_left,
  output logic [7:0]  score,
  output logic [3:0]  ducks_done,
  output logic        game_finished
);

  localparam int CW = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
  localparam logic [CW-1:0] CD_LOAD = CW'(COOLDOWN_CYCLES - 1);
  localparam logic [1:0]    SHOTS_RELOAD = 2'(SHOTS_PER_DUCK);
  localparam logic [3:0]    DUCKS_LAST   = 4'(DUCKS_PER_GAME);

  shot_state_t state_q, state_d;
  logic        left_mouse_q;
  logic        click;
  logic        hit;
  logic [11:0] mx_q, my_q, dx_q, dy_q;
  logic [CW-1:0] cd_cnt_q, cd_cnt_d;
  logic        duck_hit_q, duck_hit_d;
  logic        duck_escaped_q, duck_escaped_d;
  logic [1:0]  shots_left_q, shots_left_d;
  logic [7:0]  score_q, score_d;
  logic [3:0]  ducks_done_q, ducks_done_d;
  logic        game_finished_q, game_finished_d;

  assign click = left_mouse & ~left_mouse_q;

  hit_box_check #(
    .BOX_W (DUCK_WIDTH),
    .BOX_H (DUCK_HEIGHT)
  ) u_hit_box (
    .point_x_i (mx_q),
    .point_y_i (my_q),
    .box_x_i   (dx_q),
    .box_y_i   (dy_q),
    .hit_o     (hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      left_mouse_q    <= 1'b0;
      mx_q            <= '0;
      my_q            <= '0;
      dx_q            <= '0;
      dy_q            <= '0;
      cd_cnt_q        <= '0;
      duck_hit_q      <= 1'b0;
      duck_escaped_q  <= 1'b0;
      shots_left_q    <= SHOTS_RELOAD;
      score_q         <= '0;
      ducks_done_q    <= '0;
      game_finished_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      left_mouse_q    <= left_mouse;
      if (state_q == ARMED && click) begin
        mx_q <= mouse_xpos;
        my_q <= mouse_ypos;
        dx_q <= duck_xpos;
        dy_q <= duck_ypos;
      end
      cd_cnt_q        <= cd_cnt_d;
      duck_hit_q      <= duck_hit_d;
      duck_escaped_q  <= duck_escaped_d;
      shots_left_q    <= shots_left_d;
      score_q         <= score_d;
      ducks_done_q    <= ducks_done_d;
      game_finished_q <= game_finished_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (game_enable) state_d = ARMED;
      ARMED:    if (!game_enable) state_d = IDLE;
                else if (click) state_d = EVAL;
      EVAL:     state_d = game_enable ? COOLDOWN : IDLE;
      COOLDOWN: if (!game_enable) state_d = IDLE;
                else if (cd_cnt_q == '0)
                  state_d = (ducks_done_q == DUCKS_LAST) ? DONE : ARMED;
      DONE:     if (!game_enable) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    duck_hit_d      = 1'b0;
    duck_escaped_d  = 1'b0;
    shots_left_d    = shots_left_q;
    score_d         = score_q;
    ducks_done_d    = ducks_done_q;
    game_finished_d = (state_d == DONE);
    cd_cnt_d        = cd_cnt_q;

    if (state_q == EVAL) cd_cnt_d = CD_LOAD;
    else if (state_q == COOLDOWN && cd_cnt_q != '0) cd_cnt_d = cd_cnt_q - CW'(1);

    // leaving to IDLE wins over an in-flight evaluation
    if (state_q == IDLE || state_d == IDLE) begin
      shots_left_d = SHOTS_RELOAD;
      score_d      = '0;
      ducks_done_d = '0;
    end else if (state_q == EVAL) begin
      if (hit) begin
        duck_hit_d   = 1'b1;
        score_d      = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
        ducks_done_d = ducks_done_q + 4'd1;
        shots_left_d = SHOTS_RELOAD;
      end else if (shots_left_q > 2'd1) begin
        shots_left_d = shots_left_q - 2'd1;
      end else begin
        duck_escaped_d = 1'b1;
        ducks_done_d   = ducks_done_q + 4'd1;
        shots_left_d   = SHOTS_RELOAD;
      end
    end
  end

  assign duck_hit      = duck_hit_q;
  assign duck_escaped  = duck_escaped_q;
  assign shots_left    = shots_left_q;
  assign score         = score_q;
  assign ducks_done    = ducks_done_q;
  assign game_finished = game_finished_q;

endmodule
